// File: rtl/coef_addr_sequencer_if.sv
// Address stream from coef_addr_sequencer to the coefficient RAM readout.
// The master drives the address beat; the slave returns ready.
interface coef_addr_sequencer_if #(
    parameter int AWIDTH = 10
);
    logic [AWIDTH-1:0] tdata;
    logic              tlast;
    logic              tvalid;
    logic              tready;

    modport master (output tdata, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/coef_addr_sequencer.sv
// coef_addr_sequencer: strided, wrapping read-address sweeps for the
// coefficient RAM readout (start, length, step, repeat count, table size).
// Optional build macro COEF_ADDR_SEQ_ABORT_EN adds an abort input that
// ends the sweep early on the currently presented beat.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | no sweep in progress, waiting for go
//   RUN   | presenting addresses, advancing on each handshake
module coef_addr_sequencer #(
    parameter int AWIDTH = 10,
    parameter int RWIDTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic [AWIDTH-1:0] cfg_start,
    input  logic [AWIDTH-1:0] cfg_len_m1,
    input  logic [AWIDTH-1:0] cfg_step,
    input  logic [RWIDTH-1:0] cfg_reps_m1,
    input  logic [AWIDTH:0]   cfg_table_size,
    input  logic              go,
`ifdef COEF_ADDR_SEQ_ABORT_EN
    input  logic              abort,
`endif
    output logic              busy,
    output logic              done,
    coef_addr_sequencer_if.master o
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [AWIDTH-1:0] ONE_A = 1;
    localparam logic [RWIDTH-1:0] ONE_R = 1;

    state_t            state;
    logic [AWIDTH-1:0] start_q, len_q, step_q;
    logic [RWIDTH-1:0] reps_q;
    logic [AWIDTH:0]   tsize_q;
    logic [AWIDTH-1:0] addr, beat;
    logic [RWIDTH-1:0] rep;
    logic              tvalid_q, tlast_q;
    // Set once the presented beat has been turned into the final one by abort.
    logic              fin;

    logic              abort_req;
    logic              hs, last_beat, last_rep;
    logic [AWIDTH:0]   sum;
    logic [AWIDTH-1:0] addr_wrap, beat_nx;

`ifdef COEF_ADDR_SEQ_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign o.tdata  = addr;
    assign o.tvalid = tvalid_q;
    assign o.tlast  = tlast_q;

    // Next-address arithmetic; the subtraction result always fits in AWIDTH
    // bits because start and step are below the table size.
    always_comb begin
        hs        = tvalid_q & o.tready;
        last_beat = (beat == len_q);
        last_rep  = (rep == reps_q);
        beat_nx   = beat + ONE_A;
        sum       = {1'b0, addr} + {1'b0, step_q};
        addr_wrap = (sum >= tsize_q) ? (addr + step_q - tsize_q[AWIDTH-1:0])
                                     : (addr + step_q);
    end

    // Sequencer FSM with registered stream outputs and status.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            start_q  <= '0;
            len_q    <= '0;
            step_q   <= '0;
            reps_q   <= '0;
            tsize_q  <= '0;
            addr     <= '0;
            beat     <= '0;
            rep      <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            fin      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else if (clear) begin
            state    <= IDLE;
            start_q  <= '0;
            len_q    <= '0;
            step_q   <= '0;
            reps_q   <= '0;
            tsize_q  <= '0;
            addr     <= '0;
            beat     <= '0;
            rep      <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            fin      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (go) begin
                        start_q  <= cfg_start;
                        len_q    <= cfg_len_m1;
                        step_q   <= cfg_step;
                        reps_q   <= cfg_reps_m1;
                        tsize_q  <= cfg_table_size;
                        addr     <= cfg_start;
                        beat     <= '0;
                        rep      <= '0;
                        tvalid_q <= 1'b1;
                        tlast_q  <= (cfg_len_m1 == '0);
                        fin      <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (hs) begin
                        if (fin || (last_beat && last_rep)) begin
                            state    <= IDLE;
                            tvalid_q <= 1'b0;
                            tlast_q  <= 1'b0;
                            fin      <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end else if (last_beat) begin
                            rep     <= rep + ONE_R;
                            beat    <= '0;
                            addr    <= start_q;
                            tlast_q <= (len_q == '0) || abort_req;
                            fin     <= abort_req;
                        end else begin
                            beat    <= beat_nx;
                            addr    <= addr_wrap;
                            tlast_q <= (beat_nx == len_q) || abort_req;
                            fin     <= abort_req;
                        end
                    end else if (abort_req) begin
                        tlast_q <= 1'b1;
                        fin     <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_coef_addr_sequencer.sv
// Bench for coef_addr_sequencer: expected beats come from a closed-form
// model, addr = (start + beat*step) mod table_size, per sweep.
module tb_coef_addr_sequencer;
    localparam int AWIDTH = 10;
    localparam int RWIDTH = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              clear = 1'b0;
    logic [AWIDTH-1:0] cfg_start = '0;
    logic [AWIDTH-1:0] cfg_len_m1 = '0;
    logic [AWIDTH-1:0] cfg_step = '0;
    logic [RWIDTH-1:0] cfg_reps_m1 = '0;
    logic [AWIDTH:0]   cfg_table_size = 11'd1024;
    logic              go = 1'b0;
    logic              busy, done;
`ifdef COEF_ADDR_SEQ_ABORT_EN
    logic              abort = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    coef_addr_sequencer_if #(.AWIDTH(AWIDTH)) axis ();

    coef_addr_sequencer #(.AWIDTH(AWIDTH), .RWIDTH(RWIDTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .clear          (clear),
        .cfg_start      (cfg_start),
        .cfg_len_m1     (cfg_len_m1),
        .cfg_step       (cfg_step),
        .cfg_reps_m1    (cfg_reps_m1),
        .cfg_table_size (cfg_table_size),
        .go             (go),
`ifdef COEF_ADDR_SEQ_ABORT_EN
        .abort          (abort),
`endif
        .busy           (busy),
        .done           (done),
        .o              (axis)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_go(input int start, input int len_m1, input int step,
                            input int reps_m1, input int tsize);
        cfg_start      = AWIDTH'(start);
        cfg_len_m1     = AWIDTH'(len_m1);
        cfg_step       = AWIDTH'(step);
        cfg_reps_m1    = RWIDTH'(reps_m1);
        cfg_table_size = (AWIDTH + 1)'(tsize);
        go = 1'b1;
        tick();
        go = 1'b0;
        // Config changes after acceptance must have no effect.
        cfg_start      = AWIDTH'($urandom);
        cfg_len_m1     = AWIDTH'($urandom_range(0, 3));
        cfg_step       = AWIDTH'($urandom);
        cfg_reps_m1    = RWIDTH'($urandom_range(0, 3));
        cfg_table_size = (AWIDTH + 1)'($urandom_range(1, 1024));
    endtask

    // Runs a full sweep and checks every accepted beat against the model.
    task automatic run_case(input string name, input int start, input int len_m1,
                            input int step, input int reps_m1, input int tsize,
                            input bit stall, input bit spurious_go);
        int exp_addr[$];
        bit exp_last[$];
        int total, budget, cyc, busy_cnt;
        bit held, finished;
        logic [AWIDTH-1:0] held_data;
        logic held_last;

        for (int r = 0; r <= reps_m1; r++)
            for (int b = 0; b <= len_m1; b++) begin
                exp_addr.push_back((start + b * step) % tsize);
                exp_last.push_back(b == len_m1);
            end
        total  = exp_addr.size();
        budget = total * 8 + 20;

        axis.tready = 1'b1;
        start_go(start, len_m1, step, reps_m1, tsize);
        check({name, " first_valid"}, 32'(axis.tvalid), 1);

        held = 0; finished = 0; cyc = 0; busy_cnt = 0;
        held_data = '0; held_last = 1'b0;
        while (!finished && cyc < budget) begin
            if (busy) busy_cnt++;
            check({name, " valid"}, 32'(axis.tvalid), 1);
            check({name, " done_early"}, 32'(done), 0);
            if (held) begin
                check({name, " hold_data"}, 32'(axis.tdata), 32'(held_data));
                check({name, " hold_last"}, 32'(axis.tlast), 32'(held_last));
            end
            axis.tready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            go = spurious_go ? 1'($urandom_range(0, 1)) : 1'b0;
            if (axis.tvalid && axis.tready && exp_addr.size() > 0) begin
                check({name, " addr"}, 32'(axis.tdata), 32'(exp_addr.pop_front()));
                check({name, " last"}, 32'(axis.tlast), 32'(exp_last.pop_front()));
                held = 0;
                if (exp_addr.size() == 0) finished = 1;
            end else begin
                held      = axis.tvalid;
                held_data = axis.tdata;
                held_last = axis.tlast;
            end
            tick();
            cyc++;
        end
        go = 1'b0;
        if (!finished) check({name, " timeout"}, 0, 1);
        axis.tready = 1'($urandom_range(0, 1));
        check({name, " done_pulse"}, 32'(done), 1);
        check({name, " valid_end"}, 32'(axis.tvalid), 0);
        check({name, " busy_end"}, 32'(busy), 0);
        if (!stall) check({name, " busy_cycles"}, 32'(busy_cnt), 32'(total));
        tick();
        check({name, " done_one"}, 32'(done), 0);
        check({name, " idle_valid"}, 32'(axis.tvalid), 0);
    endtask

    initial begin
        int ts, st, sp;
        axis.tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(axis.tvalid), 0);
        check("rst_data", 32'(axis.tdata), 0);
        check("rst_last", 32'(axis.tlast), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        reset = 1'b0;
        tick();

        run_case("seq8", 0, 7, 1, 0, 1024, 0, 0);
        run_case("stride12", 5, 5, 3, 1, 12, 0, 0);
        run_case("stall8", 0, 7, 1, 0, 1024, 1, 0);
        run_case("single3", 9, 0, 1, 2, 1024, 0, 0);
        run_case("full1024", 1023, 1023, 1, 0, 1024, 0, 0);
        run_case("ovf", 1000, 9, 700, 1, 1024, 1, 1);

        // clear at beat 3 of 8
        axis.tready = 1'b1;
        start_go(0, 7, 1, 0, 1024);
        repeat (3) tick();
        check("clr_pre_beat", 32'(axis.tdata), 3);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_valid", 32'(axis.tvalid), 0);
        check("clr_busy", 32'(busy), 0);
        check("clr_done", 32'(done), 0);
        check("clr_data", 32'(axis.tdata), 0);
        repeat (2) begin
            tick();
            check("clr_no_done", 32'(done), 0);
        end
        run_case("after_clr", 0, 7, 1, 0, 1024, 0, 0);

        // clear and go together: no sweep
        cfg_start = 10'd4; cfg_len_m1 = 10'd3; cfg_step = 10'd1;
        cfg_reps_m1 = '0; cfg_table_size = 11'd1024;
        clear = 1'b1; go = 1'b1;
        tick();
        clear = 1'b0; go = 1'b0;
        check("clr_go_valid", 32'(axis.tvalid), 0);
        check("clr_go_busy", 32'(busy), 0);

        // async reset mid-cycle
        start_go(0, 7, 1, 0, 1024);
        repeat (3) tick();
        #2;
        reset = 1'b1;
        #1;
        check("arst_valid", 32'(axis.tvalid), 0);
        check("arst_data", 32'(axis.tdata), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_last", 32'(axis.tlast), 0);
        tick();
        check("arst_done", 32'(done), 0);
        reset = 1'b0;
        tick();
        run_case("after_rst", 0, 7, 1, 0, 1024, 0, 0);

        for (int i = 0; i < 6; i++) begin
            ts = $urandom_range(1, 1024);
            st = $urandom_range(0, ts - 1);
            sp = $urandom_range(0, ts - 1);
            run_case($sformatf("rnd%0d", i), st, $urandom_range(0, 20), sp,
                     $urandom_range(0, 3), ts, 1'($urandom_range(0, 1)), 1);
        end

`ifdef COEF_ADDR_SEQ_ABORT_EN
        axis.tready = 1'b1;
        start_go(0, 7, 1, 0, 1024);
        repeat (2) tick();
        check("ab_beat2", 32'(axis.tdata), 2);
        axis.tready = 1'b0;
        abort = 1'b1;
        go = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_data", 32'(axis.tdata), 2);
        check("ab_last", 32'(axis.tlast), 1);
        check("ab_valid", 32'(axis.tvalid), 1);
        tick();
        go = 1'b0;
        check("ab_hold", 32'(axis.tdata), 2);
        axis.tready = 1'b1;
        tick();
        check("ab_done", 32'(done), 1);
        check("ab_idle", 32'(axis.tvalid), 0);
        check("ab_busy", 32'(busy), 0);
        tick();
        check("ab_done_one", 32'(done), 0);
        check("ab_no_restart", 32'(axis.tvalid), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
